fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_unit_if.sv | 38 +++
 rtl/fetch_unit_adder.sv | 13 +
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, FAULT} state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: decode/execute handshake plus instruction-memory req/gnt/rvalid.
// The misaligned flag exists only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 64
) ();

  logic [XLEN-1:0] in;
  logic            inst_ready;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] out;
  logic [XLEN-1:0] PC4;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
`ifdef FETCH_ALIGN_CHECK_EN
  logic            misaligned;
`endif

  modport master (
    input  in, inst_ready, imem_gnt, imem_rvalid, imem_rdata,
`ifdef FETCH_ALIGN_CHECK_EN
    output misaligned,
`endif
    output inst_valid, inst, out, PC4, imem_req, imem_addr
  );

  modport slave (
    output in, inst_ready, imem_gnt, imem_rvalid, imem_rdata,
`ifdef FETCH_ALIGN_CHECK_EN
    input  misaligned,
`endif
    input  inst_valid, inst, out, PC4, imem_req, imem_addr
  );

endinterface

// File: rtl/fetch_unit_adder.sv
// Generic add/subtract unit: o_s = i_a + i_b when i_m=0, i_a - i_b when i_m=1.
module fetch_unit_adder #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_m,
  output logic [W-1:0] o_s
);

  assign o_s = i_m ? (i_a - i_b) : (i_a + i_b);

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, fetches one instruction at a time, hands it downstream.
// Optional FETCH_ALIGN_CHECK_EN traps a misaligned next PC into a sticky FAULT state.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  state_e          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc4;
  logic [31:0]     r_inst;
  logic            r_valid;
  logic            r_req;
`ifdef FETCH_ALIGN_CHECK_EN
  logic            r_misaligned;
`endif

  logic [XLEN-1:0] w_adder_a;
  logic [XLEN-1:0] w_pc4_next;

  // One adder serves both the reset value and the retire-time next PC4.
  assign w_adder_a = reset ? RESET_PC : bus.in;

  fetch_unit_adder #(
    .W (XLEN)
  ) u_pc4_adder (
    .i_a (w_adder_a),
    .i_b (PcStep),
    .i_m (1'b0),
    .o_s (w_pc4_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_pc4        <= w_pc4_next;
      r_inst       <= NOP_INST;
      r_valid      <= 1'b0;
      r_req        <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      case (r_state)
        BOOT: begin
          r_state <= REQ;
          r_req   <= 1'b1;
        end
        REQ: begin
          if (bus.imem_gnt) begin
            r_state <= WAIT;
            r_req   <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            r_inst  <= bus.imem_rdata;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.inst_ready) begin
            r_pc    <= bus.in;
            r_pc4   <= w_pc4_next;
            r_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (bus.in[1:0] != 2'b00) begin
              r_state      <= FAULT;
              r_misaligned <= 1'b1;
            end else begin
              r_state <= REQ;
              r_req   <= 1'b1;
            end
`else
            r_state <= REQ;
            r_req   <= 1'b1;
`endif
          end
        end
        FAULT: r_state <= FAULT;
        default: begin
          r_state <= BOOT;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inst_valid = r_valid;
  assign bus.inst       = r_inst;
  assign bus.out        = r_pc;
  assign bus.PC4        = r_pc4;
  assign bus.imem_req   = r_req;
  assign bus.imem_addr  = r_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.misaligned = r_misaligned;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default build and FETCH_ALIGN_CHECK_EN build).
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(64)) bus ();

  fetch_unit #(
    .XLEN     (64),
    .RESET_PC (64'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory contract: rvalid never coincides with gnt.
  always @(posedge clk) begin
    assert (!(bus.imem_gnt && bus.imem_rvalid)) else $error("imem gnt and rvalid overlap");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out"},   bus.out,        64'h0);
    check({tag, "_pc4"},   bus.PC4,        64'h4);
    check({tag, "_addr"},  bus.imem_addr,  64'h0);
    check({tag, "_inst"},  64'(bus.inst),  64'h13);
    check({tag, "_valid"}, 64'(bus.inst_valid), 64'h0);
    check({tag, "_req"},   64'(bus.imem_req),   64'h0);
  endtask

  // Entered with the DUT in REQ; leaves it in HOLD.
  task automatic fetch_one(input logic [63:0] pc, input logic [31:0] data);
    check("req_hi",   64'(bus.imem_req), 64'h1);
    check("req_addr", bus.imem_addr, pc);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    check("wait_req", 64'(bus.imem_req), 64'h0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    check("hold_valid", 64'(bus.inst_valid), 64'h1);
    check("hold_inst",  64'(bus.inst), 64'(data));
    check("hold_out",   bus.out, pc);
    check("hold_pc4",   bus.PC4, pc + 64'h4);
  endtask

  // Entered in HOLD with an aligned next PC; leaves the DUT in REQ.
  task automatic retire(input logic [63:0] nxt);
    bus.in         = nxt;
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    check("ret_valid", 64'(bus.inst_valid), 64'h0);
    check("ret_req",   64'(bus.imem_req), 64'h1);
    check("ret_addr",  bus.imem_addr, nxt);
    check("ret_out",   bus.out, nxt);
    check("ret_pc4",   bus.PC4, nxt + 64'h4);
  endtask

  initial begin
    logic [63:0] addrs [4];
    addrs = '{64'h0, 64'h4, 64'h8, 64'hC};
    reset           = 1'b1;
    bus.in          = '0;
    bus.inst_ready  = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;

    tick();
    tick();
    check_reset_vals("rst");
`ifdef FETCH_ALIGN_CHECK_EN
    check("rst_mis", 64'(bus.misaligned), 64'h0);
`endif
    reset = 1'b0;
    check("boot_req", 64'(bus.imem_req), 64'h0);
    tick();

    // Sequential stream 0,4,8,12 then a branch to 0x40.
    for (int i = 0; i < 4; i++) begin
      fetch_one(addrs[i], 32'h0050_0093 + 32'(i));
      retire(i == 3 ? 64'h40 : addrs[i] + 64'h4);
    end

    // Back-pressure: delayed grant, then a stalled HOLD with in toggling.
    for (int i = 0; i < 3; i++) begin
      check("bp_req",  64'(bus.imem_req), 64'h1);
      check("bp_addr", bus.imem_addr, 64'h40);
      tick();
    end
    fetch_one(64'h40, 32'hCAFE_0001);
    for (int i = 0; i < 5; i++) begin
      bus.in          = 64'h1111 * 64'(i) + 64'h3;
      bus.imem_rvalid = (i == 2);
      bus.imem_rdata  = 32'hBAD0_0000;
      tick();
      bus.imem_rvalid = 1'b0;
      check("bp_valid", 64'(bus.inst_valid), 64'h1);
      check("bp_inst",  64'(bus.inst), 64'hCAFE_0001);
      check("bp_out",   bus.out, 64'h40);
      check("bp_pc4",   bus.PC4, 64'h44);
      check("bp_noreq", 64'(bus.imem_req), 64'h0);
    end
    retire(64'h44);

    // PC4 wraps modulo 2^64.
    fetch_one(64'h44, 32'h0000_0073);
    retire(64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_pc4", bus.PC4, 64'h0);

    // Reset while waiting for data, then a spurious rvalid in REQ.
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("mid");
    tick();
    check("post_req",  64'(bus.imem_req), 64'h1);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid = 1'b0;
    check("spur_inst",  64'(bus.inst), 64'h13);
    check("spur_valid", 64'(bus.inst_valid), 64'h0);
    check("spur_req",   64'(bus.imem_req), 64'h1);
    fetch_one(64'h0, 32'h0050_0093);
    retire(64'h4);

`ifdef FETCH_ALIGN_CHECK_EN
    fetch_one(64'h4, 32'h0010_0113);
    bus.in         = 64'h42;
    bus.inst_ready = 1'b1;
    tick();
    check("mis_flag",  64'(bus.misaligned), 64'h1);
    check("mis_out",   bus.out, 64'h42);
    check("mis_pc4",   bus.PC4, 64'h46);
    for (int i = 0; i < 3; i++) begin
      bus.imem_rvalid = (i == 1);
      tick();
      bus.imem_rvalid = 1'b0;
      check("mis_noreq", 64'(bus.imem_req), 64'h0);
      check("mis_valid", 64'(bus.inst_valid), 64'h0);
    end
    bus.inst_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mis_clr", 64'(bus.misaligned), 64'h0);
    check_reset_vals("mis_rst");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
